// File: rtl/ir_hit_decoder.sv
// IR hit-sensor front end: synchronises the receiver output, measures mark/space
// widths in ticks, decodes a start+ID pulse-width frame and latches foreign hits.
module ir_hit_decoder #(
  parameter int unsigned CLK_DIV   = 400,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned OWN_ID    = 0,
  parameter int unsigned START_MIN = 200,
  parameter int unsigned START_MAX = 280,
  parameter int unsigned ZERO_MIN  = 40,
  parameter int unsigned ZERO_MAX  = 80,
  parameter int unsigned ONE_MIN   = 100,
  parameter int unsigned ONE_MAX   = 140,
  parameter int unsigned SPACE_MIN = 40,
  parameter int unsigned SPACE_MAX = 80
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  input  logic               ir_rx_n,
  input  logic               hit_clr,
  output logic               hit_data,
  output logic [ID_BITS-1:0] hit_id,
  output logic               hit_overrun,
  output logic [7:0]         err_cnt,
  output logic               busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(ID_BITS + 1);

  localparam logic [8:0] START_LO = 9'(START_MIN);
  localparam logic [8:0] START_HI = 9'(START_MAX);
  localparam logic [8:0] ZERO_LO  = 9'(ZERO_MIN);
  localparam logic [8:0] ZERO_HI  = 9'(ZERO_MAX);
  localparam logic [8:0] ONE_LO   = 9'(ONE_MIN);
  localparam logic [8:0] ONE_HI   = 9'(ONE_MAX);
  localparam logic [8:0] SPACE_LO = 9'(SPACE_MIN);
  localparam logic [8:0] SPACE_HI = 9'(SPACE_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SPACE, S_BIT, S_DONE, S_ERR_WAIT
  } state_t;

  function automatic logic in_win(input logic [8:0] w, input logic [8:0] lo,
                                  input logic [8:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic ir_meta_q, ir_s_q, ir_s_d_q;
  logic fall, rise, edge_det;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ir_meta_q <= 1'b1;
      ir_s_q    <= 1'b1;
      ir_s_d_q  <= 1'b1;
    end else begin
      ir_meta_q <= ir_rx_n;
      ir_s_q    <= ir_meta_q;
      ir_s_d_q  <= ir_s_q;
    end
  end

  assign fall     = ir_s_d_q & ~ir_s_q;
  assign rise     = ~ir_s_d_q & ir_s_q;
  assign edge_det = fall | rise;

  logic [PW-1:0] presc_q;
  logic [8:0]    width_q, width_now;
  logic          tick;

  assign tick = (presc_q == PW'(CLK_DIV - 1));
  // Include the tick of the edge cycle itself so D cycles read as floor(D/CLK_DIV).
  assign width_now = (tick && (width_q != 9'd511)) ? width_q + 9'd1 : width_q;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      presc_q <= '0;
      width_q <= '0;
    end else if (edge_det) begin
      presc_q <= '0;
      width_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      width_q <= width_now;
    end
  end

  state_t             state_q, state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ID_BITS-1:0] sr_q, sr_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d   = S_START;
        bit_cnt_d = '0;
        sr_d      = '0;
      end
      S_START: begin
        if (rise) state_d = in_win(width_now, START_LO, START_HI) ? S_SPACE : S_ERR_WAIT;
        else if (width_now > START_HI) state_d = S_ERR_WAIT;
      end
      S_SPACE: begin
        if (fall) state_d = in_win(width_now, SPACE_LO, SPACE_HI) ? S_BIT : S_ERR_WAIT;
        else if (width_now > SPACE_HI) state_d = S_ERR_WAIT;
      end
      S_BIT: begin
        if (rise) begin
          if (in_win(width_now, ZERO_LO, ZERO_HI) || in_win(width_now, ONE_LO, ONE_HI)) begin
            sr_d      = {in_win(width_now, ONE_LO, ONE_HI), sr_q[ID_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = (bit_cnt_q == BW'(ID_BITS - 1)) ? S_DONE : S_SPACE;
          end else begin
            state_d = S_ERR_WAIT;
          end
        end else if (width_now > ONE_HI) begin
          state_d = S_ERR_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      // A mark-end cycle still carries the mark width, so it never counts as idle time.
      S_ERR_WAIT: if (ir_s_q && !edge_det && (width_now > SPACE_HI)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
    end
  end

  logic               hit_data_q, hit_ovr_q, busy_q;
  logic [ID_BITS-1:0] hit_id_q;
  logic [7:0]         err_cnt_q;
  logic               accept, err_inc;

  assign accept  = (state_q == S_DONE) && (sr_q != ID_BITS'(OWN_ID));
  assign err_inc = (state_d == S_ERR_WAIT) && (state_q != S_ERR_WAIT);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      hit_data_q <= 1'b0;
      hit_ovr_q  <= 1'b0;
      hit_id_q   <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      if (accept) begin
        hit_data_q <= 1'b1;
        hit_id_q   <= sr_q;
        hit_ovr_q  <= hit_clr ? 1'b0 : (hit_ovr_q | hit_data_q);
      end else if (hit_clr) begin
        hit_data_q <= 1'b0;
        hit_ovr_q  <= 1'b0;
      end
      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      busy_q <= (state_d != S_IDLE);
    end
  end

  assign hit_data    = hit_data_q;
  assign hit_id      = hit_id_q;
  assign hit_overrun = hit_ovr_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ir_hit_decoder.sv
// Directed and randomized frames for ir_hit_decoder, checked against a
// frame-level model that classifies widths directly from the decoding rules.
module tb_ir_hit_decoder;

  localparam int CLK_DIV = 4;

  logic       PCLK = 1'b0;
  logic       PRESERN = 1'b0;
  logic       ir_rx_n = 1'b1;
  logic       hit_clr = 1'b0;
  logic       hit_data;
  logic [3:0] hit_id;
  logic       hit_overrun;
  logic [7:0] err_cnt;
  logic       busy;

  ir_hit_decoder #(.CLK_DIV(CLK_DIV)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .ir_rx_n(ir_rx_n), .hit_clr(hit_clr),
    .hit_data(hit_data), .hit_id(hit_id), .hit_overrun(hit_overrun),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_fail = 0;

  // model of the visible outputs
  logic       m_hit = 1'b0;
  logic       m_ovr = 1'b0;
  logic [3:0] m_id = 4'd0;
  int         m_err = 0;

  // current frame description, widths in ticks
  int f_start;
  int f_sp[4];
  int f_mk[4];
  int f_nb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hit_data"}, 32'(hit_data), 32'(m_hit));
    check({tag, ".hit_id"}, 32'(hit_id), 32'(m_id));
    check({tag, ".hit_overrun"}, 32'(hit_overrun), 32'(m_ovr));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Drive a level for an exact number of ticks; returns 1 ns after a rising edge.
  task automatic hold(input logic val, input int ticks);
    ir_rx_n = val;
    repeat (ticks * CLK_DIV) @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_clr();
    hit_clr = 1'b1;
    @(posedge PCLK);
    #1;
    hit_clr = 1'b0;
    m_hit = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic set_frame(input logic [3:0] id);
    f_start = 240;
    f_nb = 4;
    for (int i = 0; i < 4; i++) begin
      f_sp[i] = 60;
      f_mk[i] = id[i] ? 120 : 60;
    end
  endtask

  // Frame outcome straight from the width windows: 1 = well-formed, id returned.
  function automatic bit classify(output logic [3:0] id);
    id = 4'd0;
    if (f_start < 200 || f_start > 280) return 1'b0;
    for (int i = 0; i < f_nb; i++) begin
      if (f_sp[i] < 40 || f_sp[i] > 80) return 1'b0;
      if (f_mk[i] >= 40 && f_mk[i] <= 80) id[i] = 1'b0;
      else if (f_mk[i] >= 100 && f_mk[i] <= 140) id[i] = 1'b1;
      else return 1'b0;
    end
    return (f_nb == 4);
  endfunction

  task automatic send_frame(input string tag, input bit clr_at_done, input bit chk_lat);
    logic [3:0] id;
    bit ok;
    hold(1'b0, f_start);
    check({tag, ".busy_in_frame"}, 32'(busy), 32'd1);
    for (int i = 0; i < f_nb; i++) begin
      hold(1'b1, f_sp[i]);
      hold(1'b0, f_mk[i]);
    end
    // final mark end: first sampled on the next edge, hit visible after the 4th edge
    ir_rx_n = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    if (chk_lat) check({tag, ".lat_before"}, 32'(hit_data), 32'd0);
    if (clr_at_done) hit_clr = 1'b1;
    @(posedge PCLK);
    #1;
    hit_clr = 1'b0;
    if (chk_lat) check({tag, ".lat_at4"}, 32'(hit_data), 32'd1);
    ok = classify(id);
    if (ok) begin
      if (id != 4'd0) begin
        m_ovr = clr_at_done ? 1'b0 : (m_ovr | m_hit);
        m_hit = 1'b1;
        m_id  = id;
      end else if (clr_at_done) begin
        m_hit = 1'b0;
        m_ovr = 1'b0;
      end
    end else begin
      if (m_err < 255) m_err++;
      if (clr_at_done) begin
        m_hit = 1'b0;
        m_ovr = 1'b0;
      end
    end
    hold(1'b1, ok ? 10 : 100);
    check_all(tag);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge PCLK);
    #1;
    check_all("reset");
    PRESERN = 1'b1;
    hold(1'b1, 5);

    // ID 5 with latency check
    set_frame(4'd5);
    send_frame("id5", 1'b0, 1'b1);
    pulse_clr();
    check_all("clr1");

    // own ID is silently dropped
    set_frame(4'd0);
    send_frame("own_id", 1'b0, 1'b0);

    // short start mark, long idle, then ID 3
    set_frame(4'd5);
    f_start = 150;
    send_frame("short_start", 1'b0, 1'b0);
    hold(1'b1, 300);
    set_frame(4'd3);
    send_frame("id3", 1'b0, 1'b0);

    // start-window boundaries
    set_frame(4'd12);
    f_start = 200;
    send_frame("start_min", 1'b0, 1'b0);
    set_frame(4'd10);
    f_start = 280;
    send_frame("start_max", 1'b0, 1'b0);
    set_frame(4'd11);
    f_start = 281;
    send_frame("start_over", 1'b0, 1'b0);

    // overrun then clear
    set_frame(4'd2);
    send_frame("id2", 1'b0, 1'b0);
    set_frame(4'd7);
    send_frame("id7", 1'b0, 1'b0);
    pulse_clr();
    check_all("clr2");

    // hit_clr coinciding with DONE: set wins, overrun stays clear
    set_frame(4'd4);
    send_frame("id4", 1'b0, 1'b0);
    set_frame(4'd9);
    send_frame("id9_clr", 1'b1, 1'b0);

    // truncated after two bits
    set_frame(4'd15);
    f_nb = 2;
    send_frame("trunc", 1'b0, 1'b0);

    // reset mid-frame
    hold(1'b0, 240);
    hold(1'b1, 60);
    hold(1'b0, 120);
    ir_rx_n = 1'b1;
    repeat (20) @(posedge PCLK);
    #1;
    PRESERN = 1'b0;
    #1;
    m_hit = 1'b0;
    m_ovr = 1'b0;
    m_id  = 4'd0;
    m_err = 0;
    check_all("midreset");
    repeat (3) @(posedge PCLK);
    #1;
    PRESERN = 1'b1;
    hold(1'b1, 20);
    set_frame(4'd6);
    send_frame("after_reset", 1'b0, 1'b0);

    // randomized frames, some with one corrupted element
    for (int n = 0; n < 6; n++) begin
      logic [3:0] rid;
      rid = 4'($urandom_range(0, 15));
      f_start = $urandom_range(200, 280);
      f_nb = 4;
      for (int i = 0; i < 4; i++) begin
        f_sp[i] = $urandom_range(40, 80);
        f_mk[i] = rid[i] ? $urandom_range(100, 140) : $urandom_range(40, 80);
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: f_start = $urandom_range(100, 199);
          1: f_start = $urandom_range(281, 320);
          2: f_sp[$urandom_range(0, 3)] = $urandom_range(10, 39);
          default: f_mk[$urandom_range(0, 3)] = $urandom_range(81, 99);
        endcase
      end
      send_frame($sformatf("rand%0d", n), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_all($sformatf("rand_clr%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
